// File: rtl/semaforo_entrada_if.sv
// Signal bundle between raw panel inputs and the traffic-light controller.
// master: drives raw switch/button and ack; slave: conditioning stage.
interface semaforo_entrada_if;
    logic sw_alerta;
    logic btn_ped;
    logic ped_ack;
    logic a;
    logic tick;
    logic ped_req;

    modport master (
        output sw_alerta,
        output btn_ped,
        output ped_ack,
        input  a,
        input  tick,
        input  ped_req
    );

    modport slave (
        input  sw_alerta,
        input  btn_ped,
        input  ped_ack,
        output a,
        output tick,
        output ped_req
    );
endinterface

// File: rtl/semaforo_entrada.sv
// Input conditioning ahead of the traffic-light controller: sync + debounce
// of the alert switch (a), free-running tick prescaler, and an optional
// sticky pedestrian request (macro SEMAFORO_PED_REQ_EN).
// Ports: clk, rst (async, active-low), bus (slave: sw_alerta, btn_ped,
// ped_ack in; a, tick, ped_req out).
module semaforo_entrada #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    semaforo_entrada_if.slave     bus
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] C_MAX = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TICK_DIV - 1);

    // Alert path
    logic [1:0]    sa_q;
    logic          da_q, da_d;
    logic [CW-1:0] ca_q, ca_d;

    // Tick prescaler
    logic [TW-1:0] t_q, t_d;
    logic          tick_q, tick_d;

    always_comb begin
        da_d = da_q;
        ca_d = '0;
        if (sa_q[1] != da_q) begin
            if (ca_q == C_MAX) begin
                da_d = ~da_q;
            end else begin
                ca_d = ca_q + 1'b1;
            end
        end
    end

    always_comb begin
        tick_d = (t_q == T_MAX);
        t_d    = tick_d ? '0 : t_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sa_q   <= '0;
            da_q   <= 1'b0;
            ca_q   <= '0;
            t_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            sa_q   <= {sa_q[0], bus.sw_alerta};
            da_q   <= da_d;
            ca_q   <= ca_d;
            t_q    <= t_d;
            tick_q <= tick_d;
        end
    end

    assign bus.a    = da_q;
    assign bus.tick = tick_q;

`ifdef SEMAFORO_PED_REQ_EN
    logic [1:0]    sp_q;
    logic          dp_q, dp_d;
    logic          dp_prev_q;
    logic [CW-1:0] cp_q, cp_d;
    logic          req_q, req_d;
    logic          rise;

    always_comb begin
        dp_d = dp_q;
        cp_d = '0;
        if (sp_q[1] != dp_q) begin
            if (cp_q == C_MAX) begin
                dp_d = ~dp_q;
            end else begin
                cp_d = cp_q + 1'b1;
            end
        end
    end

    // Set beats clear so a press coinciding with an ack is kept.
    always_comb begin
        rise  = dp_q & ~dp_prev_q;
        req_d = rise | (req_q & ~bus.ped_ack);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q      <= '0;
            dp_q      <= 1'b0;
            dp_prev_q <= 1'b0;
            cp_q      <= '0;
            req_q     <= 1'b0;
        end else begin
            sp_q      <= {sp_q[0], bus.btn_ped};
            dp_q      <= dp_d;
            dp_prev_q <= dp_q;
            cp_q      <= cp_d;
            req_q     <= req_d;
        end
    end

    assign bus.ped_req = req_q;
`else
    logic unused_ped;
    assign unused_ped  = bus.btn_ped ^ bus.ped_ack;
    assign bus.ped_req = 1'b0;
`endif
endmodule

// File: doc/semaforo_entrada.md
# semaforo_entrada

Input-conditioning stage placed directly upstream of the traffic-light controller. It synchronizes and debounces the raw alert switch and produces the controller's `a` input, and generates a periodic one-cycle `tick` strobe for slow-timebase use. It also latches a debounced pedestrian push-button into a sticky request that the downstream controller acknowledges. All logic runs in the single system clock domain.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per `tick` period; must be ≥ 2.
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required before a debounced level changes; must be ≥ 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sw_alerta`  in  1  raw alert switch; asynchronous to `clk` and bouncy.
- `btn_ped`  in  1  raw pedestrian button; asynchronous and bouncy; high while pressed.
- `ped_ack`  in  1  one-cycle pulse from the downstream controller that clears `ped_req`.
- `a`  out  1  debounced alert level, registered.
- `tick`  out  1  one-cycle strobe, once every `TICK_DIV` cycles.
- `ped_req`  out  1  sticky pedestrian request.

## Operation
- **Synchronizer.** Each raw input passes through its own two-flop synchronizer. The output of the second flop is `s_x`.
- **Debouncer.** There is one per input. It holds a debounced level `d_x` and a counter `c_x` of width `$clog2(DB_CYCLES)`.
  - When `s_x == d_x`: `c_x` is cleared to 0.
  - When `s_x != d_x` and `c_x == DB_CYCLES-1`: `d_x` toggles and `c_x` is cleared to 0.
  - Otherwise `c_x` increments.
  - Any glitch shorter than `DB_CYCLES` cycles restarts the count and produces no output change.
- **Alert output.** `a = d_alerta`, driven straight from the register.
- **Tick prescaler.** Counter `t` runs 0..`TICK_DIV-1` and wraps to 0.
  - `tick` is registered and is high for exactly the one cycle after `t` reaches `TICK_DIV-1`.
  - The prescaler free-runs and is independent of all inputs.
- **Pedestrian request.**
  - Set condition: a rising edge of `d_ped`, i.e. the cycle `d_ped` goes 0→1. It is detected with a one-cycle-delayed copy of `d_ped`.
  - `ped_req` stays set until `ped_ack` is seen.
  - If set and clear occur in the same cycle, set wins and `ped_req` stays 1, so a new press is never lost.
  - Holding the button produces only one set. Releasing it has no effect.

## Timing
- **Reset.** While `rst` is low, all registers are 0: synchronizers, `d_x`, `c_x`, `t`, `a`, `tick`, and `ped_req`. Reset assertion takes effect immediately (asynchronous). State restarts from these values at the first edge after deassertion.
- **Reset mid-count.** A partially counted debounce or tick period is discarded. No `tick` is emitted during reset.
- **Tick period.** The first `tick` is high in cycle `TICK_DIV` after reset release. Subsequent ticks are exactly `TICK_DIV` cycles apart.
- **Alert latency.** Let edge 0 be the first rising edge that samples a new stable raw level. Then `s_x` changes after edge 1 and `a` changes after edge `DB_CYCLES+1`.
- **Pedestrian request latency.** `ped_req` rises one edge after `d_ped` rises.
- **Clear latency.** `ped_req` falls on the edge that samples `ped_ack` high, unless a set occurs in that same cycle.
- **Input constraint.** `ped_ack` is synchronous to `clk`. No other timing requirement is placed on `ped_ack`.

## Configuration
- Macro: `SEMAFORO_PED_REQ_EN`.
- **Defined:** the pedestrian synchronizer, debouncer, edge detector and request latch are compiled in, with behaviour as described above.
- **Undefined:** that logic is absent and `ped_req` is tied to constant 0. `btn_ped` and `ped_ack` are ignored. `a` and `tick` behave identically in both builds.

## Test plan
Benches use `TICK_DIV=5` and `DB_CYCLES=4`.
1. **Reset state:** hold `rst`=0 for 3 cycles → `a`=0, `tick`=0, `ped_req`=0. Release `rst` → `tick` pulses high in cycles 5, 10, 15, one cycle wide each.
2. **Alert debounce:** set `sw_alerta`=1 before edge 0 and hold it → `a` rises after edge 5 (= `DB_CYCLES`+1). Then set `sw_alerta`=0 and hold it → `a` falls 5 edges later.
3. **Glitch rejection:** pulse `sw_alerta` high for 3 cycles, then return it low → `a` stays 0 throughout.
4. **Pedestrian request:** press `btn_ped` for 10 cycles → `ped_req` rises once and stays 1 after release. Pulse `ped_ack` for one cycle → `ped_req`=0 on that edge.
5. **Simultaneous set and clear:** align `ped_ack` with the `d_ped` rising-edge cycle → `ped_req` remains 1. Build without `SEMAFORO_PED_REQ_EN` and repeat the button stimulus → `ped_req` stays 0 throughout.
6. **Asynchronous reset mid-operation:** with the alert debounce counter at 2, drive `rst` low between clock edges → all outputs go to 0 immediately. After release, `a` needs a full `DB_CYCLES`+1 edges of stable input before it changes.
